// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the UART frame checker
package uart_pkg;

    // Frame position tracked by the checker
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } uart_state_t;

    // Parity type encoding on par_typ
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Ceiling log2, used to size the data bit index
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// rtl/uart_sat_counter.sv - saturating event counter with synchronous clear
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   inc   - count one event this cycle
//   clr   - synchronous clear, wins over inc
//   count - current count, sticks at all-ones
module uart_sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/uart_frame_check.sv
// rtl/uart_frame_check.sv - sequential UART frame checker: data shift, parity, stop bits
//
// Ports:
//   CLK, RST      - clock and asynchronous active-high reset
//   frame_start   - start bit confirmed; next bit_valid is data bit 0
//   bit_valid     - sampled_bit is valid for the current frame position
//   sampled_bit   - majority-sampled line value
//   par_en        - parity bit present (latched at frame_start)
//   par_typ       - 0 even / 1 odd (latched at frame_start)
//   clr_cnt       - synchronous clear of both error counters
//   p_data        - data of the last error-free frame
//   data_valid    - pulse: clean frame completed
//   par_err       - pulse: frame completed with parity mismatch
//   stp_err       - pulse: frame ended on a zero stop bit
//   busy          - frame in progress
//   par_err_cnt   - saturating parity error count
//   stp_err_cnt   - saturating stop error count
module uart_frame_check
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  frame_start,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  clr_cnt,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

    localparam int IDX_W = clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  stop_idx_q, stop_idx_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_mis_q, par_mis_d;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_valid_q, par_err_q, stp_err_q;

    // Frame-ending events, decided in the cycle of the ending bit_valid
    logic end_ok, end_par, end_stp;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_mis_d  = par_mis_q;
        end_ok     = 1'b0;
        end_par    = 1'b0;
        end_stp    = 1'b0;

        // frame_start restarts from any state and swallows a coincident bit_valid
        if (frame_start) begin
            state_d    = DATA;
            par_en_d   = par_en;
            par_typ_d  = par_typ;
            shift_d    = '0;
            idx_d      = '0;
            stop_idx_d = 1'b0;
            par_mis_d  = 1'b0;
        end else if (bit_valid) begin
            case (state_q)
                DATA: begin
                    // LSB arrives first, so shifting in at the top leaves bit 0 at the bottom
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    if (idx_q == LAST_IDX) begin
                        state_d    = par_en_q ? PARITY : STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                PARITY: begin
                    par_mis_d = sampled_bit ^ (^shift_q) ^ par_typ_q;
                    state_d   = STOP;
                end
                STOP: begin
                    if (!sampled_bit) begin
                        end_stp = 1'b1;
                        state_d = IDLE;
                    end else if (stop_idx_q == LAST_STOP) begin
                        state_d = IDLE;
                        if (par_mis_q) begin
                            end_par = 1'b1;
                        end else begin
                            end_ok = 1'b1;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            idx_q        <= '0;
            stop_idx_q   <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_mis_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            stop_idx_q   <= stop_idx_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_mis_q    <= par_mis_d;
            data_valid_q <= end_ok;
            par_err_q    <= end_par;
            stp_err_q    <= end_stp;
            if (end_ok) begin
                p_data_q <= shift_q;
            end
        end
    end

    uart_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (end_par),
        .clr   (clr_cnt),
        .count (par_err_cnt)
    );

    uart_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stp_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (end_stp),
        .clr   (clr_cnt),
        .count (stp_err_cnt)
    );

    assign p_data     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    // state_q is registered, so busy falls on the same edge that raises the completion pulse
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_check.sv
// tb/tb_uart_frame_check.sv - directed self-checking bench for uart_frame_check
module tb_uart_frame_check;

    logic CLK, RST;
    logic frame_start, bit_valid, sampled_bit, par_en, par_typ, clr_cnt;

    // d_: defaults (8 data, 1 stop, 8-bit counters)
    logic [7:0] d_pdata; logic d_dv, d_pe, d_se, d_busy; logic [7:0] d_pcnt, d_scnt;
    // s_: two stop bits
    logic [7:0] s_pdata; logic s_dv, s_pe, s_se, s_busy; logic [7:0] s_pcnt, s_scnt;
    // c_: 2-bit counters
    logic [7:0] c_pdata; logic c_dv, c_pe, c_se, c_busy; logic [1:0] c_pcnt, c_scnt;

    int checks = 0;
    int errors = 0;
    int dv_seen = 0;

    uart_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(8)) u_def (
        .CLK(CLK), .RST(RST), .frame_start(frame_start), .bit_valid(bit_valid),
        .sampled_bit(sampled_bit), .par_en(par_en), .par_typ(par_typ), .clr_cnt(clr_cnt),
        .p_data(d_pdata), .data_valid(d_dv), .par_err(d_pe), .stp_err(d_se), .busy(d_busy),
        .par_err_cnt(d_pcnt), .stp_err_cnt(d_scnt));

    uart_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2), .CNT_WIDTH(8)) u_stop2 (
        .CLK(CLK), .RST(RST), .frame_start(frame_start), .bit_valid(bit_valid),
        .sampled_bit(sampled_bit), .par_en(par_en), .par_typ(par_typ), .clr_cnt(clr_cnt),
        .p_data(s_pdata), .data_valid(s_dv), .par_err(s_pe), .stp_err(s_se), .busy(s_busy),
        .par_err_cnt(s_pcnt), .stp_err_cnt(s_scnt));

    uart_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(2)) u_cnt2 (
        .CLK(CLK), .RST(RST), .frame_start(frame_start), .bit_valid(bit_valid),
        .sampled_bit(sampled_bit), .par_en(par_en), .par_typ(par_typ), .clr_cnt(clr_cnt),
        .p_data(c_pdata), .data_valid(c_dv), .par_err(c_pe), .stp_err(c_se), .busy(c_busy),
        .par_err_cnt(c_pcnt), .stp_err_cnt(c_scnt));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Counts data_valid pulses of the default instance (sampled before the edge updates it)
    always @(posedge CLK) dv_seen <= dv_seen + int'(d_dv);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic start_frame();
        @(negedge CLK); frame_start = 1'b1;
        @(negedge CLK); frame_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge CLK); bit_valid = 1'b1; sampled_bit = b;
        @(negedge CLK); bit_valid = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(negedge CLK); @(negedge CLK);
        checks++; if ({d_pdata, d_dv, d_pe, d_se, d_busy} !== 12'h000) begin errors++;
            $display("FAIL reset_outputs: got %h expected 000", {d_pdata, d_dv, d_pe, d_se, d_busy}); end
        checks++; if ({d_pcnt, d_scnt} !== 16'h0000) begin errors++;
            $display("FAIL reset_counters: got %h expected 0000", {d_pcnt, d_scnt}); end
        RST = 1'b0;
        // bit_valid in IDLE must be ignored
        send_bit(1'b0);
        checks++; if ({d_busy, d_se} !== 2'b00) begin errors++;
            $display("FAIL idle_bit_ignored: got %b expected 00", {d_busy, d_se}); end
    endtask

    task automatic test_clean_nopar();
        par_en = 1'b0; par_typ = 1'b0;
        start_frame();
        checks++; if (d_busy !== 1'b1) begin errors++;
            $display("FAIL nopar_busy_rise: got %b expected 1", d_busy); end
        send_data(8'hA5);
        checks++; if ({d_busy, d_dv} !== 2'b10) begin errors++;
            $display("FAIL nopar_before_stop: got %b expected 10", {d_busy, d_dv}); end
        send_bit(1'b1);
        checks++; if ({d_dv, d_pe, d_se, d_busy} !== 4'b1000) begin errors++;
            $display("FAIL nopar_pulse: got %b expected 1000", {d_dv, d_pe, d_se, d_busy}); end
        checks++; if (d_pdata !== 8'hA5) begin errors++;
            $display("FAIL nopar_pdata: got %h expected a5", d_pdata); end
        @(negedge CLK);
        checks++; if (d_dv !== 1'b0) begin errors++;
            $display("FAIL nopar_single_pulse: got %b expected 0", d_dv); end
    endtask

    task automatic test_parity();
        par_en = 1'b1; par_typ = 1'b0;
        start_frame(); send_data(8'hA5); send_bit(1'b0); send_bit(1'b1);
        checks++; if ({d_dv, d_pe, d_se} !== 3'b100) begin errors++;
            $display("FAIL even_ok: got %b expected 100", {d_dv, d_pe, d_se}); end
        start_frame(); send_data(8'hA5); send_bit(1'b1); send_bit(1'b1);
        checks++; if ({d_dv, d_pe, d_se} !== 3'b010) begin errors++;
            $display("FAIL even_bad: got %b expected 010", {d_dv, d_pe, d_se}); end
        checks++; if (d_pcnt !== 8'd1) begin errors++;
            $display("FAIL even_bad_cnt: got %0d expected 1", d_pcnt); end
        checks++; if (d_pdata !== 8'hA5) begin errors++;
            $display("FAIL even_bad_hold: got %h expected a5", d_pdata); end
        // Odd parity latched at frame_start; mid-frame config change must not matter
        par_typ = 1'b1;
        start_frame();
        par_en = 1'b0; par_typ = 1'b0;
        send_data(8'h07); send_bit(1'b0); send_bit(1'b1);
        checks++; if ({d_dv, d_pe, d_se} !== 3'b100) begin errors++;
            $display("FAIL odd_latched: got %b expected 100", {d_dv, d_pe, d_se}); end
        checks++; if (d_pdata !== 8'h07) begin errors++;
            $display("FAIL odd_pdata: got %h expected 07", d_pdata); end
    endtask

    task automatic test_stop2();
        par_en = 1'b0; par_typ = 1'b0;
        start_frame(); send_data(8'h3C); send_bit(1'b1);
        checks++; if ({s_busy, s_se, s_dv} !== 3'b100) begin errors++;
            $display("FAIL stop2_first_one: got %b expected 100", {s_busy, s_se, s_dv}); end
        send_bit(1'b0);
        checks++; if ({s_busy, s_se, s_dv, s_pe} !== 4'b0100) begin errors++;
            $display("FAIL stop2_second_zero: got %b expected 0100", {s_busy, s_se, s_dv, s_pe}); end
        checks++; if (s_scnt !== 8'd1) begin errors++;
            $display("FAIL stop2_cnt1: got %0d expected 1", s_scnt); end
        start_frame(); send_data(8'h3C); send_bit(1'b0);
        checks++; if ({s_busy, s_se} !== 2'b01) begin errors++;
            $display("FAIL stop2_first_zero: got %b expected 01", {s_busy, s_se}); end
        checks++; if (s_scnt !== 8'd2) begin errors++;
            $display("FAIL stop2_cnt2: got %0d expected 2", s_scnt); end
        send_bit(1'b1);
        checks++; if ({s_busy, s_se, s_dv} !== 3'b000) begin errors++;
            $display("FAIL stop2_idle_strobe: got %b expected 000", {s_busy, s_se, s_dv}); end
    endtask

    task automatic test_abort();
        int base;
        par_en = 1'b0;
        base = dv_seen;
        start_frame();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        start_frame(); send_data(8'h5A); send_bit(1'b1);
        checks++; if (d_pdata !== 8'h5A) begin errors++;
            $display("FAIL abort_pdata: got %h expected 5a", d_pdata); end
        @(negedge CLK);
        checks++; if (dv_seen - base !== 1) begin errors++;
            $display("FAIL abort_pulses: got %0d expected 1", dv_seen - base); end
        // Coincident frame_start/bit_valid: the 1 must not become data bit 0
        @(negedge CLK); frame_start = 1'b1; bit_valid = 1'b1; sampled_bit = 1'b1;
        @(negedge CLK); frame_start = 1'b0; bit_valid = 1'b0;
        send_data(8'h00); send_bit(1'b1);
        checks++; if ({d_dv, d_se, d_pdata} !== 10'b10_0000_0000) begin errors++;
            $display("FAIL coincident_start: got dv=%b se=%b pdata=%h expected dv=1 se=0 pdata=00",
                     d_dv, d_se, d_pdata); end
    endtask

    task automatic test_saturate();
        par_en = 1'b0;
        @(negedge CLK); clr_cnt = 1'b1;
        @(negedge CLK); clr_cnt = 1'b0;
        checks++; if ({c_pcnt, c_scnt} !== 4'b0000) begin errors++;
            $display("FAIL clr_cnt: got %b expected 0000", {c_pcnt, c_scnt}); end
        for (int n = 1; n <= 5; n++) begin
            start_frame(); send_data(8'h11); send_bit(1'b0);
            checks++; if ({c_se, c_scnt} !== {1'b1, 2'((n > 3) ? 3 : n)}) begin errors++;
                $display("FAIL sat_frame%0d: got se=%b cnt=%0d expected se=1 cnt=%0d",
                         n, c_se, c_scnt, (n > 3) ? 3 : n); end
        end
        checks++; if (d_pdata !== 8'h00) begin errors++;
            $display("FAIL pdata_hold_stperr: got %h expected 00", d_pdata); end
        start_frame(); send_data(8'h11);
        @(negedge CLK); bit_valid = 1'b1; sampled_bit = 1'b0; clr_cnt = 1'b1;
        @(negedge CLK); bit_valid = 1'b0; clr_cnt = 1'b0;
        checks++; if ({c_se, c_scnt} !== 3'b100) begin errors++;
            $display("FAIL clr_wins: got se=%b cnt=%0d expected se=1 cnt=0", c_se, c_scnt); end
    endtask

    task automatic test_reset_mid();
        par_en = 1'b0;
        start_frame();
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        #2 RST = 1'b1;
        #1;
        checks++; if ({d_pdata, d_dv, d_pe, d_se, d_busy, d_pcnt, d_scnt} !== 28'h0) begin errors++;
            $display("FAIL reset_mid: got pdata=%h busy=%b pcnt=%0d scnt=%0d expected all 0",
                     d_pdata, d_busy, d_pcnt, d_scnt); end
        @(negedge CLK); RST = 1'b0;
        start_frame(); send_data(8'hFF); send_bit(1'b1);
        checks++; if ({d_dv, d_pdata} !== 9'h1FF) begin errors++;
            $display("FAIL after_reset_frame: got dv=%b pdata=%h expected dv=1 pdata=ff", d_dv, d_pdata); end
    endtask

    initial begin
        RST = 1'b1; frame_start = 1'b0; bit_valid = 1'b0; sampled_bit = 1'b0;
        par_en = 1'b0; par_typ = 1'b0; clr_cnt = 1'b0;
        test_reset();
        test_clean_nopar();
        test_parity();
        test_stop2();
        test_abort();
        test_saturate();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
